// File: rtl/matrix_stream_tx_if.sv
// Matrix element stream between a transmitter (master) and a matrix IP (slave).
interface matrix_stream_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/matrix_stream_tx.sv
// Buffers a SIZE x SIZE matrix and streams it out row-major or column-major
// (on-the-fly transpose) with full backpressure and tlast on the final element.
module matrix_stream_tx #(
  parameter int SIZE       = 6,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic                  col_major,
  output logic                  busy,
  output logic                  done,
  matrix_stream_tx_if.master    out
);
  localparam int unsigned DEPTH = SIZE * SIZE;
  localparam int          CW    = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [CW-1:0]         row;
  logic [CW-1:0]         col;
  logic                  col_major_q;
  logic                  tvalid_q;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  at_last;

  assign idx     = ADDR_WIDTH'(row) * ADDR_WIDTH'(SIZE) + ADDR_WIDTH'(col);
  assign at_last = (row == LAST) && (col == LAST);

  // Buffer is intentionally outside reset so contents survive rst; frozen while sending.
  always_ff @(posedge clk) begin
    if (state == IDLE && wr_en && (32'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      tvalid_q    <= 1'b0;
      row         <= '0;
      col         <= '0;
      col_major_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= SEND;
            busy        <= 1'b1;
            tvalid_q    <= 1'b1;
            row         <= '0;
            col         <= '0;
            col_major_q <= col_major;
          end
        end
        SEND: begin
          if (out.tready) begin
            if (at_last) begin
              state    <= IDLE;
              busy     <= 1'b0;
              tvalid_q <= 1'b0;
              done     <= 1'b1;
              row      <= '0;
              col      <= '0;
            end else if (!col_major_q) begin
              if (col == LAST) begin
                col <= '0;
                row <= row + CW'(1);
              end else begin
                col <= col + CW'(1);
              end
            end else begin
              if (row == LAST) begin
                row <= '0;
                col <= col + CW'(1);
              end else begin
                row <= row + CW'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data and tlast derive only from registered state, so they hold during stalls.
  assign out.tvalid = tvalid_q;
  assign out.tdata  = tvalid_q ? mem[idx] : '0;
  assign out.tlast  = tvalid_q && at_last;
endmodule

// File: tb/tb_matrix_stream_tx.sv
// Self-checking bench for matrix_stream_tx: a queue-based expected-beat model
// compared every cycle, plus literal checks on ordering, latency and reset.
module tb_matrix_stream_tx;
  localparam int SIZE = 6;
  localparam int DW   = 8;
  localparam int AW   = 6;
  localparam int N    = SIZE * SIZE;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk_tb = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          col_major;
  logic          busy;
  logic          done;

  matrix_stream_tx_if #(.DATA_WIDTH(DW)) s_if ();

  matrix_stream_tx #(.SIZE(SIZE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk_tb),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .col_major (col_major),
    .busy      (busy),
    .done      (done),
    .out       (s_if)
  );

  always #5 clk_tb = ~clk_tb;

  int checks     = 0;
  int failures   = 0;
  int done_count = 0;
  int last_count = 0;
  bit cmp_en     = 1'b0;

  logic [DW-1:0] m_mem [N];
  beat_t         exp_q [$];
  logic          m_done = 1'b0;
  logic [DW-1:0] cap [$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a transfer is just the list of beats it must emit, built at start-accept.
  always @(posedge clk_tb) begin
    if (rst) begin
      exp_q.delete();
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (exp_q.size() != 0) begin
        if (s_if.tready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_done = 1'b1;
        end
      end else begin
        if (wr_en && int'(wr_addr) < N) m_mem[wr_addr] = wr_data;
        if (start) begin
          for (int k = 0; k < N; k++) begin
            beat_t b;
            int a;
            a = col_major ? (k % SIZE) * SIZE + (k / SIZE) : k;
            b.data = m_mem[a];
            b.last = (k == N - 1);
            exp_q.push_back(b);
          end
        end
      end
    end
  end

  always @(negedge clk_tb) begin
    if (cmp_en) begin
      logic          e_act;
      logic [DW-1:0] e_data;
      logic          e_last;
      e_act  = exp_q.size() != 0;
      e_data = e_act ? exp_q[0].data : '0;
      e_last = e_act ? exp_q[0].last : 1'b0;
      checkOutput("busy", 32'(busy), 32'(e_act));
      checkOutput("tvalid", 32'(s_if.tvalid), 32'(e_act));
      checkOutput("tdata", 32'(s_if.tdata), 32'(e_data));
      checkOutput("tlast", 32'(s_if.tlast), 32'(e_last));
      checkOutput("done", 32'(done), 32'(m_done));
      if (done === 1'b1) done_count++;
      if (s_if.tvalid === 1'b1 && s_if.tready === 1'b1) begin
        cap.push_back(s_if.tdata);
        if (s_if.tlast === 1'b1) last_count++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_tb);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    step(1);
    wr_en   = 1'b0;
  endtask

  // Returns in the done cycle; cycles counts from the start-sampling cycle to done.
  task automatic run_transfer(input logic cm, input bit toggle, input bit poke, output int cycles);
    cap.delete();
    start        = 1'b1;
    col_major    = cm;
    s_if.tready  = 1'b1;
    step(1);
    start     = 1'b0;
    wr_en     = 1'b0;
    col_major = ~cm;
    cycles    = 1;
    while (done !== 1'b1 && cycles < 300) begin
      step(1);
      cycles++;
      if (toggle) s_if.tready = ~s_if.tready;
      if (poke && cycles == 5) begin
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = 8'hFF;
        start   = 1'b1;
      end else if (poke && cycles == 7) begin
        wr_en = 1'b0;
        start = 1'b0;
      end
    end
    s_if.tready = 1'b1;
    col_major   = 1'b0;
  endtask

  initial begin
    int cyc;
    int prev_done;
    int prev_last;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; col_major = 1'b0; s_if.tready = 1'b1;
    step(1);
    cmp_en = 1'b1;
    step(2);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_tvalid", 32'(s_if.tvalid), 0);
    checkOutput("rst_tdata", 32'(s_if.tdata), 0);
    checkOutput("rst_done", 32'(done), 0);
    rst = 1'b0;
    step(1);

    for (int i = 0; i < N; i++) applyStimulus(AW'(i), DW'(i));
    applyStimulus(AW'(40), 8'hAA);
    step(1);

    prev_last = last_count;
    run_transfer(1'b0, 1'b0, 1'b0, cyc);
    checkOutput("rm_cycles", 32'(cyc), 37);
    checkOutput("rm_beats", 32'(cap.size()), 36);
    for (int k = 0; k < N; k++) checkOutput("rm_data", 32'(cap[k]), 32'(k));
    checkOutput("rm_tlast_cnt", 32'(last_count - prev_last), 1);
    step(2);

    run_transfer(1'b1, 1'b0, 1'b0, cyc);
    checkOutput("cm_beat1", 32'(cap[1]), 6);
    checkOutput("cm_beat5", 32'(cap[5]), 30);
    checkOutput("cm_beat6", 32'(cap[6]), 1);
    checkOutput("cm_beat7", 32'(cap[7]), 7);
    checkOutput("cm_beat34", 32'(cap[34]), 29);
    checkOutput("cm_beat35", 32'(cap[35]), 35);
    step(2);

    run_transfer(1'b0, 1'b1, 1'b0, cyc);
    checkOutput("stall_cycles", 32'(cyc), 72);
    checkOutput("stall_beats", 32'(cap.size()), 36);
    checkOutput("stall_beat20", 32'(cap[20]), 20);
    step(2);

    run_transfer(1'b0, 1'b0, 1'b1, cyc);
    checkOutput("poke_cycles", 32'(cyc), 37);
    prev_done = done_count;
    prev_last = last_count;
    run_transfer(1'b1, 1'b0, 1'b0, cyc);
    checkOutput("b2b_beat0", 32'(cap[0]), 0);
    checkOutput("b2b_beat1", 32'(cap[1]), 6);
    checkOutput("b2b_cycles", 32'(cyc), 37);
    run_transfer(1'b0, 1'b0, 1'b0, cyc);
    checkOutput("b2b_done_cnt", 32'(done_count - prev_done), 2);
    checkOutput("b2b_last_cnt", 32'(last_count - prev_last), 2);
    step(2);

    cap.delete();
    start = 1'b1; col_major = 1'b0; s_if.tready = 1'b1;
    step(1);
    start = 1'b0;
    step(10);
    checkOutput("pre_rst_tdata", 32'(s_if.tdata), 10);
    prev_done = done_count;
    rst = 1'b1;
    step(1);
    checkOutput("mid_rst_tvalid", 32'(s_if.tvalid), 0);
    checkOutput("mid_rst_busy", 32'(busy), 0);
    checkOutput("mid_rst_tlast", 32'(s_if.tlast), 0);
    rst = 1'b0;
    step(3);
    checkOutput("mid_rst_no_done", 32'(done_count - prev_done), 0);
    run_transfer(1'b0, 1'b0, 1'b0, cyc);
    checkOutput("post_rst_beat0", 32'(cap[0]), 0);
    checkOutput("post_rst_beat10", 32'(cap[10]), 10);
    checkOutput("post_rst_cycles", 32'(cyc), 37);
    step(2);

    wr_en = 1'b1; wr_addr = '0; wr_data = 8'h5A;
    run_transfer(1'b0, 1'b0, 1'b0, cyc);
    checkOutput("wr_start_beat0", 32'(cap[0]), 32'h5A);
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
